// File: rtl/time_manager.sv
// Emulated-time arbiter: picks the earliest next-event time across N clock sources,
// broadcasts it while running below the limit, and tracks committed time and fired sources.
package time_package;
  localparam int TIME_WIDTH = 16;
endpackage

// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | broadcasting t_min while it is within time_limit
// PAUSE | emulated time held by pause
// DONE  | next event is past time_limit; start resumes without clearing history
module time_manager #(
  parameter int N          = 2,
  parameter int TIME_WIDTH = time_package::TIME_WIDTH,
  parameter int STEP_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*TIME_WIDTH-1:0] time_clocks,
  input  logic                    start,
  input  logic                    pause,
  input  logic [TIME_WIDTH-1:0]   time_limit,
  output logic [TIME_WIDTH-1:0]   time_next,
  output logic                    advance,
  output logic [TIME_WIDTH-1:0]   time_curr,
  output logic [N-1:0]            fire_mask,
  output logic [STEP_WIDTH-1:0]   step_count,
  output logic [1:0]              state,
  output logic                    err
);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("time_manager: N must be in 1..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [TIME_WIDTH-1:0] t_min;
  logic [N-1:0]          hit;
  logic                  any_max;
  logic                  seen_adv;

  always_comb begin
    t_min = time_clocks[0 +: TIME_WIDTH];
    for (int i = 1; i < N; i++) begin
      if (time_clocks[i*TIME_WIDTH +: TIME_WIDTH] < t_min) t_min = time_clocks[i*TIME_WIDTH +: TIME_WIDTH];
    end
  end

  // All-ones is reserved as the "no event" broadcast value, so a source reporting it is an error.
  always_comb begin
    hit     = '0;
    any_max = 1'b0;
    for (int i = 0; i < N; i++) begin
      hit[i]  = (time_clocks[i*TIME_WIDTH +: TIME_WIDTH] == t_min);
      any_max = any_max | (time_clocks[i*TIME_WIDTH +: TIME_WIDTH] == {TIME_WIDTH{1'b1}});
    end
  end

  assign advance   = (state_q == ST_RUN) && !pause && (t_min <= time_limit);
  assign time_next = advance ? t_min : {TIME_WIDTH{1'b1}};
  assign state     = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = pause ? ST_PAUSE : ST_RUN;
      end
      ST_RUN: begin
        if (pause)                   state_d = ST_PAUSE;
        else if (t_min > time_limit) state_d = ST_DONE;
      end
      ST_PAUSE: begin
        if (!pause) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      time_curr  <= '0;
      fire_mask  <= '0;
      step_count <= '0;
      err        <= 1'b0;
      seen_adv   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (any_max || (advance && seen_adv && (t_min < time_curr))) err <= 1'b1;
      if (advance) begin
        time_curr <= t_min;
        fire_mask <= hit;
        seen_adv  <= 1'b1;
        if (step_count != {STEP_WIDTH{1'b1}}) step_count <= step_count + STEP_WIDTH'(1);
      end else begin
        fire_mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_time_manager.sv
// Randomized and directed bench for time_manager (N=2, 16-bit time) against a
// behavioural model of the emulated-time rules.
module tb_time_manager;

  logic        clk;
  logic        rst_n;
  logic [15:0] ct [2];
  logic [31:0] time_clocks;
  logic        start;
  logic        pause;
  logic [15:0] time_limit;
  logic [15:0] time_next;
  logic        advance;
  logic [15:0] time_curr;
  logic [1:0]  fire_mask;
  logic [31:0] step_count;
  logic [1:0]  state;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  // behavioural model
  int          m_state;
  int          m_curr;
  int          m_mask;
  longint      m_steps;
  bit          m_err;
  bit          m_seen;

  assign time_clocks = {ct[1], ct[0]};

  time_manager #(.N(2), .TIME_WIDTH(16), .STEP_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .time_clocks(time_clocks),
    .start      (start),
    .pause      (pause),
    .time_limit (time_limit),
    .time_next  (time_next),
    .advance    (advance),
    .time_curr  (time_curr),
    .fire_mask  (fire_mask),
    .step_count (step_count),
    .state      (state),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_min();
    int m = 32'h7fffffff;
    foreach (ct[i]) if (int'(ct[i]) < m) m = int'(ct[i]);
    return m;
  endfunction

  function automatic bit ref_adv();
    return (m_state == 1) && !pause && (ref_min() <= int'(time_limit));
  endfunction

  task automatic model_reset();
    m_state = 0; m_curr = 0; m_mask = 0; m_steps = 0; m_err = 0; m_seen = 0;
  endtask

  task automatic model_edge();
    int  tmin = ref_min();
    bit  adv  = ref_adv();
    int  nxt  = m_state;
    foreach (ct[i]) if (ct[i] == 16'hFFFF) m_err = 1;
    if (adv) begin
      if (m_seen && tmin < m_curr) m_err = 1;
      m_curr = tmin;
      m_mask = 0;
      foreach (ct[i]) if (int'(ct[i]) == tmin) m_mask |= (1 << i);
      if (m_steps < 64'hFFFF_FFFF) m_steps++;
      m_seen = 1;
    end else begin
      m_mask = 0;
    end
    if (m_state == 0 || m_state == 3) begin
      if (start) nxt = pause ? 2 : 1;
    end else if (m_state == 1) begin
      if (pause) nxt = 2;
      else if (tmin > int'(time_limit)) nxt = 3;
    end else begin
      if (!pause) nxt = 1;
    end
    m_state = nxt;
  endtask

  task automatic check_all();
    bit adv = rst_n ? ref_adv() : 1'b0;
    check("state",      64'(state),      64'(m_state));
    check("advance",    64'(advance),    64'(adv));
    check("time_next",  64'(time_next),  adv ? 64'(ref_min()) : 64'hFFFF);
    check("time_curr",  64'(time_curr),  64'(m_curr));
    check("fire_mask",  64'(fire_mask),  64'(m_mask));
    check("step_count", 64'(step_count), 64'(m_steps));
    check("err",        64'(err),        64'(m_err));
  endtask

  task automatic step_cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; time_limit = 16'd100;
    ct[0] = 16'd10; ct[1] = 16'd15;
    model_reset();
    @(negedge clk);
    do_reset();

    // first advance after start
    start = 1'b1; step_cycle(); start = 1'b0;
    step_cycle();
    check("first_curr", 64'(time_curr), 64'd10);
    check("first_mask", 64'(fire_mask), 64'd1);
    check("first_step", 64'(step_count), 64'd1);

    // tie
    ct[0] = 16'd20; ct[1] = 16'd20; step_cycle();
    check("tie_mask", 64'(fire_mask), 64'd3);
    check("tie_step", 64'(step_count), 64'd2);

    // limit boundary
    time_limit = 16'd50; ct[0] = 16'd50; ct[1] = 16'd60; step_cycle();
    check("lim_curr", 64'(time_curr), 64'd50);
    ct[0] = 16'd60; step_cycle();
    check("lim_done", 64'(state), 64'd3);
    step_cycle();
    start = 1'b1; step_cycle(); start = 1'b0;
    check("lim_restart", 64'(state), 64'd1);
    check("lim_keep", 64'(time_curr), 64'd50);
    step_cycle();

    // pause mid-run
    time_limit = 16'd200; ct[0] = 16'd70; ct[1] = 16'd80;
    start = 1'b1; step_cycle(); start = 1'b0;
    step_cycle();
    pause = 1'b1;
    repeat (3) step_cycle();
    check("pause_mask", 64'(fire_mask), 64'd0);
    check("pause_hold", 64'(time_curr), 64'd70);
    pause = 1'b0; step_cycle();
    ct[0] = 16'd90; ct[1] = 16'd95; step_cycle();
    check("resume_curr", 64'(time_curr), 64'd90);

    // non-monotonic error
    do_reset();
    time_limit = 16'd100; ct[0] = 16'd40; ct[1] = 16'd45;
    start = 1'b1; step_cycle(); start = 1'b0;
    step_cycle();
    ct[0] = 16'd30; ct[1] = 16'd70; step_cycle();
    check("err_set", 64'(err), 64'd1);
    ct[0] = 16'd50; ct[1] = 16'd60; repeat (2) step_cycle();
    check("err_sticky", 64'(err), 64'd1);

    // all-ones source error, even in IDLE
    do_reset();
    ct[0] = 16'd5; ct[1] = 16'hFFFF; step_cycle();
    check("err_max", 64'(err), 64'd1);

    // reset mid-run
    do_reset();
    ct[0] = 16'd10; ct[1] = 16'd20; time_limit = 16'd100;
    start = 1'b1; step_cycle(); start = 1'b0;
    repeat (2) step_cycle();
    do_reset();
    check("rst_state", 64'(state), 64'd0);
    check("rst_steps", 64'(step_count), 64'd0);

    // randomized traffic
    base = 0;
    for (int n = 0; n < 400; n++) begin
      base += int'($urandom_range(0, 5));
      foreach (ct[i]) ct[i] = 16'(base + int'($urandom_range(0, 8)));
      if ($urandom_range(0, 32) == 0) ct[0] = 16'($urandom_range(0, 200));
      if ($urandom_range(0, 99) == 0) ct[1] = 16'hFFFF;
      time_limit = ($urandom_range(0, 9) == 0) ? 16'(base - 5) : 16'(base + int'($urandom_range(0, 30)));
      start = ($urandom_range(0, 9) == 0);
      pause = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      else step_cycle();
    end
    start = 1'b0; pause = 1'b0;
    step_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/time_manager.md
TIME_MANAGER -- requirements
Module: time_manager

Interface
REQ-001 Parameter N, default 2, SHALL set the number of clock sources (legal 1..8); any other value SHALL raise an elaboration error.
REQ-002 Parameter TIME_WIDTH, default time_package TIME_WIDTH, SHALL set the unsigned width of every time value.
REQ-003 Parameter STEP_WIDTH, default 32, SHALL set the width of step_count.
REQ-004 clk  input  1  SHALL be the single emulator clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 time_clocks  input  N*TIME_WIDTH  SHALL carry the packed next-event time of each clock source; source i occupies bits [i*TIME_WIDTH +: TIME_WIDTH].
REQ-007 start  input  1  SHALL be a one-cycle request to leave IDLE or DONE.
REQ-008 pause  input  1  SHALL be a level request to hold emulated time.
REQ-009 time_limit  input  TIME_WIDTH  SHALL be the last emulated time allowed to fire; it is sampled every cycle.
REQ-010 time_next  output  TIME_WIDTH  SHALL be the time broadcast to all clock sources for equality comparison.
REQ-011 advance  output  1  SHALL be high in cycles where time_next carries a valid event time.
REQ-012 time_curr  output  TIME_WIDTH  SHALL be the registered last committed emulated time.
REQ-013 fire_mask  output  N  SHALL be the registered set of sources that fired on the last advance.
REQ-014 step_count  output  STEP_WIDTH  SHALL count advances.
REQ-015 state  output  2  SHALL expose the FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-016 err  output  1  SHALL be a sticky error flag.

Function
REQ-017 t_min SHALL be the combinational unsigned minimum of all N time_clocks entries.
REQ-018 advance SHALL equal (state==RUN) & ~pause & (t_min <= time_limit), combinationally, with zero latency.
REQ-019 time_next SHALL equal t_min when advance=1, and all-ones (2^TIME_WIDTH-1) otherwise.
REQ-020 On a clock edge with advance=1: time_curr<=t_min; fire_mask[i]<=(time_clocks[i]==t_min) for every i (ties set several bits); step_count<=step_count+1, saturating at all-ones.
REQ-021 With advance=0, time_curr, fire_mask and step_count SHALL hold, except that fire_mask SHALL clear to 0 on the first edge after advance=0.
REQ-022 IDLE: start=1 -> RUN; otherwise stay.
REQ-023 RUN: pause=1 -> PAUSE; else t_min > time_limit -> DONE; else stay.
REQ-024 PAUSE: pause=0 -> RUN, re-evaluating the limit on the next cycle.
REQ-025 DONE: start=1 -> RUN without clearing time_curr or step_count; otherwise stay.
REQ-026 If start and pause are both high in IDLE or DONE, the FSM SHALL enter PAUSE.
REQ-027 When t_min == time_limit the event SHALL fire, and DONE SHALL be entered only on a later cycle.
REQ-028 err SHALL set on an advance edge if t_min < time_curr (non-monotonic time), excluding the first advance after reset.
REQ-029 err SHALL set on any edge where any time_clocks entry equals all-ones.
REQ-030 err SHALL clear only on reset.
REQ-031 No time arithmetic other than comparison SHALL be performed, so no wrap handling is needed.

Reset
REQ-032 While rst_n=0, asynchronously: state=IDLE, time_curr=0, fire_mask=0, step_count=0, err=0.
REQ-033 During reset, advance SHALL be 0 and time_next all-ones.
REQ-034 Reset asserted mid-RUN SHALL abort immediately with no partial update, and the FSM SHALL require a new start after release.

Verification
REQ-035 N=2, W=16, limit=100, clocks {10,15}, start -> RUN; next cycle advance=1, time_next=10; after edge time_curr=10, fire_mask=01, step_count=1.
REQ-036 Tie: clocks {20,20} in RUN -> time_next=20; after edge fire_mask=11, step_count increments by exactly 1.
REQ-037 Limit boundary: limit=50, clocks {50,60} -> advance=1 at 50; next cycle clocks {60,60} -> advance=0, time_next=FFFF, state->DONE; start -> RUN, time_curr still 50.
REQ-038 Pause mid-run: pause=1 for 3 cycles -> advance=0, time_next=FFFF, outputs held, fire_mask=0; pause=0 -> RUN, then advance resumes.
REQ-039 Error: after time_curr=40, drive clocks {30,70} -> err=1 after edge and stays 1; separately, drive any clock=FFFF -> err=1.
REQ-040 Reset mid-run: assert rst_n=0 between edges -> state=IDLE, time_curr=0, step_count=0, err=0 before the next edge.
